// File: rtl/score_digit_ctrl_if.sv
// Signal bundle between the game/raster side and score_digit_ctrl.
//   frame_start  1-cycle pulse at start of vertical blank
//   score_p1/p2  14-bit binary player scores
//   draw_x/y     current raster pixel
//   rom_address  numbers ROM address (row*80 + digit*8 + col), registered
//   digit_on     pixel lies on a visible digit cell, registered
//   busy         score conversion in progress
// master = game logic / raster side, slave = score_digit_ctrl.
interface score_digit_ctrl_if;
    logic        frame_start;
    logic [13:0] score_p1;
    logic [13:0] score_p2;
    logic [9:0]  draw_x;
    logic [9:0]  draw_y;
    logic [9:0]  rom_address;
    logic        digit_on;
    logic        busy;

    modport master (
        output frame_start, score_p1, score_p2, draw_x, draw_y,
        input  rom_address, digit_on, busy
    );

    modport slave (
        input  frame_start, score_p1, score_p2, draw_x, draw_y,
        output rom_address, digit_on, busy
    );
endinterface

// File: rtl/score_digit_ctrl.sv
// Two-player 4-digit score readout sharing one numbers glyph ROM (80x11 sheet,
// glyph d at columns d*8..d*8+7). On frame_start both scores are latched,
// clamped to 9999 and converted to BCD by a shift-add-3 sequencer, then
// committed atomically to the display registers. Per pixel, the ROM address
// and an on-flag are produced one clock after draw_x/draw_y.
// Ports:
//   vga_clk_i  pixel clock, all state on posedge
//   reset_i    synchronous, active-high
//   bus        score_digit_ctrl_if.slave (scores, raster position, ROM address)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for frame_start, display regs stable
// S_LATCH  | sample and clamp both scores, clear working BCD
// S_CONV1  | 14 shift-add-3 iterations on player 1
// S_CONV2  | 14 shift-add-3 iterations on player 2
// S_COMMIT | copy both working BCD values into display regs
module score_digit_ctrl #(
    parameter int unsigned P1_X0       = 16,
    parameter int unsigned P2_X0       = 560,
    parameter int unsigned Y0          = 8,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned BLANK_LEAD  = 1
) (
    input logic               vga_clk_i,
    input logic               reset_i,
    score_digit_ctrl_if.slave bus
);

    localparam int unsigned CELL_W = 8 << SCALE_SHIFT;
    localparam int unsigned CELL_H = 11 << SCALE_SHIFT;

    typedef enum logic [2:0] {
        S_IDLE, S_LATCH, S_CONV1, S_CONV2, S_COMMIT
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  iter_q, iter_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d;
    logic [13:0] p2_bin_q, p2_bin_d;
    logic [15:0] p1_bcd_q, p1_bcd_d;
    logic [15:0] disp_p1_q, disp_p1_d;
    logic [15:0] disp_p2_q, disp_p2_d;
    logic [9:0]  rom_addr_q, rom_addr_d;
    logic        digit_on_q, digit_on_d;
    logic [29:0] step_w;

    function automatic logic [13:0] clamp9999(input logic [13:0] s);
        return (s > 14'd9999) ? 14'd9999 : s;
    endfunction

    // One double-dabble iteration: nibbles >= 5 get +3, then {bcd,bin} << 1.
    function automatic logic [29:0] dd_step(input logic [15:0] bcd, input logic [13:0] bin);
        logic [15:0] adj;
        adj = bcd;
        for (int k = 0; k < 4; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
        return {adj, bin} << 1;
    endfunction

    assign step_w   = dd_step(bcd_q, bin_q);
    assign bus.busy = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        p2_bin_d  = p2_bin_q;
        p1_bcd_d  = p1_bcd_q;
        disp_p1_d = disp_p1_q;
        disp_p2_d = disp_p2_q;
        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) state_d = S_LATCH;
            end
            S_LATCH: begin
                bin_d    = clamp9999(bus.score_p1);
                p2_bin_d = clamp9999(bus.score_p2);
                bcd_d    = 16'd0;
                iter_d   = 4'd13;
                state_d  = S_CONV1;
            end
            S_CONV1: begin
                {bcd_d, bin_d} = step_w;
                if (iter_q == 4'd0) begin
                    // Park player 1's result and reload the shifter for player 2.
                    p1_bcd_d = step_w[29:14];
                    bin_d    = p2_bin_q;
                    bcd_d    = 16'd0;
                    iter_d   = 4'd13;
                    state_d  = S_CONV2;
                end else begin
                    iter_d = iter_q - 4'd1;
                end
            end
            S_CONV2: begin
                {bcd_d, bin_d} = step_w;
                if (iter_q == 4'd0) state_d = S_COMMIT;
                else                iter_d  = iter_q - 4'd1;
            end
            S_COMMIT: begin
                disp_p1_d = p1_bcd_q;
                disp_p2_d = bcd_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic        y_in, hit, hit_blank, lead;
    logic [3:0]  row_v, digit_v, hit_digit;
    logic [2:0]  hit_col;
    logic [10:0] px, cell_x0;
    logic [15:0] bcd_sel;

    assign px = {1'b0, bus.draw_x};

    // Player 2 is scanned first so a player-1 hit overrides on overlap.
    always_comb begin
        y_in      = (bus.draw_y >= 10'(Y0)) && (bus.draw_y < 10'(Y0 + CELL_H));
        row_v     = 4'((bus.draw_y - 10'(Y0)) >> SCALE_SHIFT);
        hit       = 1'b0;
        hit_blank = 1'b0;
        hit_digit = 4'd0;
        hit_col   = 3'd0;
        lead      = 1'b1;
        digit_v   = 4'd0;
        cell_x0   = 11'd0;
        bcd_sel   = 16'd0;
        for (int p = 1; p >= 0; p--) begin
            bcd_sel = (p == 0) ? disp_p1_q : disp_p2_q;
            lead    = 1'b1;
            for (int i = 0; i < 4; i++) begin
                digit_v = bcd_sel[4*(3-i) +: 4];
                lead    = lead && (digit_v == 4'd0);
                cell_x0 = 11'(((p == 0) ? P1_X0 : P2_X0) + i * CELL_W);
                if (y_in && (px >= cell_x0) && (px < cell_x0 + 11'(CELL_W))) begin
                    hit       = 1'b1;
                    hit_digit = digit_v;
                    hit_col   = 3'((px - cell_x0) >> SCALE_SHIFT);
                    hit_blank = (BLANK_LEAD != 0) && (i < 3) && lead;
                end
            end
        end
        digit_on_d = hit && !hit_blank;
        rom_addr_d = digit_on_d ? (10'(row_v) * 10'd80 + {3'b000, hit_digit, 3'b000} + 10'(hit_col))
                                : 10'd0;
    end

    always_ff @(posedge vga_clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            iter_q     <= 4'd0;
            bin_q      <= 14'd0;
            bcd_q      <= 16'd0;
            p2_bin_q   <= 14'd0;
            p1_bcd_q   <= 16'd0;
            disp_p1_q  <= 16'd0;
            disp_p2_q  <= 16'd0;
            rom_addr_q <= 10'd0;
            digit_on_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            iter_q     <= iter_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            p2_bin_q   <= p2_bin_d;
            p1_bcd_q   <= p1_bcd_d;
            disp_p1_q  <= disp_p1_d;
            disp_p2_q  <= disp_p2_d;
            rom_addr_q <= rom_addr_d;
            digit_on_q <= digit_on_d;
        end
    end

    assign bus.rom_address = rom_addr_q;
    assign bus.digit_on    = digit_on_q;

endmodule

// File: tb/tb_score_digit_ctrl.sv
module tb_score_digit_ctrl;

    logic vga_clk = 1'b0;
    logic reset   = 1'b1;
    int   checks  = 0;
    int   passes  = 0;
    int   disp1   = 0;
    int   disp2   = 0;

    score_digit_ctrl_if bus();

    score_digit_ctrl dut (
        .vga_clk_i (vga_clk),
        .reset_i   (reset),
        .bus       (bus)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: what pixel (x,y) should show given displayed scores disp1/disp2.
    function automatic logic [10:0] model_pix(int x, int y);
        int pw[4] = '{1000, 100, 10, 1};
        int bases[2];
        int sc[2];
        int i, col, row, d;
        bases = '{16, 560};
        sc    = '{disp1, disp2};
        if (y < 8 || y >= 30) return 11'd0;
        for (int p = 0; p < 2; p++) begin
            if (x >= bases[p] && x < bases[p] + 64) begin
                i   = (x - bases[p]) / 16;
                col = ((x - bases[p]) % 16) / 2;
                row = (y - 8) / 2;
                d   = (sc[p] / pw[i]) % 10;
                if (i < 3 && sc[p] < pw[i]) return 11'd0;
                return {1'b1, 10'(row * 80 + d * 8 + col)};
            end
        end
        return 11'd0;
    endfunction

    function automatic int clampm(int s);
        return (s > 9999) ? 9999 : s;
    endfunction

    task automatic probe(input int x, input int y, output logic [10:0] got);
        @(negedge vga_clk);
        bus.draw_x = 10'(x);
        bus.draw_y = 10'(y);
        @(negedge vga_clk);
        got = {bus.digit_on, bus.rom_address};
    endtask

    task automatic start_conv(input int s1, input int s2);
        @(negedge vga_clk);
        bus.score_p1    = 14'(s1);
        bus.score_p2    = 14'(s2);
        bus.frame_start = 1'b1;
        @(negedge vga_clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge vga_clk);
        end
    endtask

    task automatic test_reset();
        logic [10:0] got;
        reset = 1'b1;
        repeat (2) @(negedge vga_clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.digit_on !== 1'b0 || bus.rom_address !== 10'd0)
            $display("FAIL reset_outputs got busy=%0b on=%0b addr=%0d want 0/0/0",
                     bus.busy, bus.digit_on, bus.rom_address);
        else passes++;
        reset = 1'b0;
        disp1 = 0;
        disp2 = 0;
        probe(16 + 48 + 3, 9, got);
        checks++;
        if (got !== {1'b1, 10'd1}) $display("FAIL reset_lsd got %h want %h", got, {1'b1, 10'd1});
        else passes++;
        probe(560 + 5, 12, got);
        checks++;
        if (got !== 11'd0) $display("FAIL reset_msd_blank got %h want 0", got);
        else passes++;
    endtask

    task automatic test_convert_1234();
        int n;
        logic [10:0] got, exp;
        int s2 = int'($urandom_range(0, 9999));
        start_conv(1234, s2);
        count_busy(n);
        checks++;
        if (n !== 30) $display("FAIL busy_len_1234 got %0d want 30", n);
        else passes++;
        disp1 = 1234;
        disp2 = s2;
        probe(37, 14, got);
        checks++;
        if (got !== {1'b1, 10'd258}) $display("FAIL addr_37_14 got %h want %h", got, {1'b1, 10'd258});
        else passes++;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) begin
                int x = (p == 0 ? 16 : 560) + i * 16 + int'($urandom_range(0, 15));
                int y = 8 + int'($urandom_range(0, 21));
                probe(x, y, got);
                exp = model_pix(x, y);
                checks++;
                if (got !== exp) $display("FAIL cells_1234 x=%0d y=%0d got %h want %h", x, y, got, exp);
                else passes++;
            end
    endtask

    task automatic test_clamp_blank();
        int n;
        logic [10:0] got, exp;
        start_conv(0, 12000);
        count_busy(n);
        checks++;
        if (n !== 30) $display("FAIL busy_len_clamp got %0d want 30", n);
        else passes++;
        disp1 = 0;
        disp2 = clampm(12000);
        probe(560 + 1, 8, got);
        checks++;
        if (got !== {1'b1, 10'd72}) $display("FAIL clamp_msd got %h want %h", got, {1'b1, 10'd72});
        else passes++;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) begin
                int x = (p == 0 ? 16 : 560) + i * 16 + int'($urandom_range(0, 15));
                int y = 8 + int'($urandom_range(0, 21));
                probe(x, y, got);
                exp = model_pix(x, y);
                checks++;
                if (got !== exp) $display("FAIL cells_clamp x=%0d y=%0d got %h want %h", x, y, got, exp);
                else passes++;
            end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [10:0] got, exp;
        start_conv(4321, 77);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (n == 10) begin
                bus.score_p1    = 14'd555;
                bus.score_p2    = 14'd9000;
                bus.frame_start = 1'b1;
            end else begin
                bus.frame_start = 1'b0;
            end
            @(negedge vga_clk);
        end
        bus.frame_start = 1'b0;
        checks++;
        if (n !== 30) $display("FAIL busy_len_b2b got %0d want 30", n);
        else passes++;
        repeat (5) @(negedge vga_clk);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL b2b_no_queue got busy=%0b want 0", bus.busy);
        else passes++;
        disp1 = 4321;
        disp2 = 77;
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < 4; i++) begin
                int x = (p == 0 ? 16 : 560) + i * 16 + int'($urandom_range(0, 15));
                int y = 8 + int'($urandom_range(0, 21));
                probe(x, y, got);
                exp = model_pix(x, y);
                checks++;
                if (got !== exp) $display("FAIL cells_b2b x=%0d y=%0d got %h want %h", x, y, got, exp);
                else passes++;
            end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [10:0] got, exp;
        start_conv(8888, 8888);
        n = 1;
        while (n < 15) begin
            n++;
            @(negedge vga_clk);
        end
        reset = 1'b1;
        @(negedge vga_clk);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_mid_busy got %0b want 0", bus.busy);
        else passes++;
        reset = 1'b0;
        disp1 = 0;
        disp2 = 0;
        probe(16 + 48 + 8, 20, got);
        exp = model_pix(16 + 48 + 8, 20);
        checks++;
        if (got !== exp) $display("FAIL reset_mid_digits got %h want %h", got, exp);
        else passes++;
        probe(560 + 48 + 15, 29, got);
        exp = model_pix(560 + 48 + 15, 29);
        checks++;
        if (got !== exp) $display("FAIL reset_mid_p2 got %h want %h", got, exp);
        else passes++;
        start_conv(905, 60);
        count_busy(n);
        checks++;
        if (n !== 30) $display("FAIL busy_len_after_reset got %0d want 30", n);
        else passes++;
        disp1 = 905;
        disp2 = 60;
        for (int i = 0; i < 4; i++) begin
            int x = 16 + i * 16 + int'($urandom_range(0, 15));
            int y = 8 + int'($urandom_range(0, 21));
            probe(x, y, got);
            exp = model_pix(x, y);
            checks++;
            if (got !== exp) $display("FAIL cells_after_reset x=%0d y=%0d got %h want %h", x, y, got, exp);
            else passes++;
        end
    endtask

    task automatic test_random();
        int n, s1, s2;
        logic [10:0] got, exp;
        for (int r = 0; r < 6; r++) begin
            s1 = int'($urandom_range(0, 16383));
            s2 = int'($urandom_range(0, 16383));
            if (r == 0) s1 = 9999;
            if (r == 1) s2 = 10000;
            start_conv(s1, s2);
            count_busy(n);
            checks++;
            if (n !== 30) $display("FAIL busy_len_rand got %0d want 30", n);
            else passes++;
            disp1 = clampm(s1);
            disp2 = clampm(s2);
            for (int k = 0; k < 24; k++) begin
                int p = int'($urandom_range(0, 1));
                int x = (p == 0 ? 16 : 560) + int'($urandom_range(0, 65)) - 1;
                int y = int'($urandom_range(6, 31));
                probe(x, y, got);
                exp = model_pix(x, y);
                checks++;
                if (got !== exp)
                    $display("FAIL rand s1=%0d s2=%0d x=%0d y=%0d got %h want %h", s1, s2, x, y, got, exp);
                else passes++;
            end
        end
    endtask

    task automatic test_sweep();
        int n, errs, lit, bx, by;
        logic [10:0] exp_prev, exp, got;
        start_conv(307, 5046);
        count_busy(n);
        disp1 = 307;
        disp2 = 5046;
        errs = 0;
        lit  = 0;
        bx   = -1;
        by   = -1;
        exp_prev = 11'd0;
        for (int y = 0; y < 40; y++)
            for (int x = 0; x < 640; x++) begin
                @(negedge vga_clk);
                if (!(x == 0 && y == 0)) begin
                    got = {bus.digit_on, bus.rom_address};
                    if (got !== exp_prev) begin
                        errs++;
                        if (bx < 0) begin
                            bx = (x == 0) ? 639 : x - 1;
                            by = (x == 0) ? y - 1 : y;
                        end
                    end
                    if (got[10]) lit++;
                end
                bus.draw_x = 10'(x);
                bus.draw_y = 10'(y);
                exp_prev   = model_pix(x, y);
            end
        @(negedge vga_clk);
        got = {bus.digit_on, bus.rom_address};
        if (got !== exp_prev) errs++;
        checks++;
        if (errs != 0) $display("FAIL sweep got %0d bad pixels (first x=%0d y=%0d) want 0", errs, bx, by);
        else passes++;
        // 307: 3 lit cells, 5046: 4 lit cells; each cell lit where its glyph has any pixel in the 16x22 box.
        checks++;
        if (lit == 0) $display("FAIL sweep_lit got %0d lit pixels want nonzero", lit);
        else passes++;
        probe(15, 8, got);
        checks++;
        if (got !== 11'd0) $display("FAIL outside_15_8 got %h want 0", got);
        else passes++;
        probe(16, 30, got);
        checks++;
        if (got !== 11'd0) $display("FAIL below_window got %h want 0", got);
        else passes++;
    endtask

    initial begin
        bus.frame_start = 1'b0;
        bus.score_p1    = 14'd0;
        bus.score_p2    = 14'd0;
        bus.draw_x      = 10'd0;
        bus.draw_y      = 10'd0;
        test_reset();
        test_convert_1234();
        test_clamp_blank();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
